seg7_byte_controller: RTL and testbench
=======================================

SEG7_BYTE_CONTROLLER -- requirements
Module: seg7_byte_controller

Interface
REQ-001 Parameter HOLD_CYCLES, default 25000000, number of i_Clk cycles a byte stays displayed after capture; legal range 2 and above.
REQ-002 Parameter BLINK_HALF, default 6250000, cycles per on or off half-period in BLINK; legal range 1 and above.
REQ-003 Parameter BLINK_COUNT, default 4, number of complete off/on blink periods before blanking; legal range 1 and above.
REQ-004 i_Clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 i_Rst  input  1  reset, asynchronous, active-high.
REQ-006 i_RX_DV  input  1  single-cycle strobe; i_RX_Byte valid.
REQ-007 i_RX_Byte  input  8  byte from the UART receiver.
REQ-008 i_TX_DV  input  1  single-cycle strobe; i_TX_Byte valid.
REQ-009 i_TX_Byte  input  8  byte from the UART transmitter.
REQ-010 o_Upper_Nibble  output  4  bits 7:4 of the displayed byte, to the left-digit decoder.
REQ-011 o_Lower_Nibble  output  4  bits 3:0 of the displayed byte, to the right-digit decoder.
REQ-012 o_Blank  output  1  1 = both digits off; board logic forces all segments off.
REQ-013 o_Source  output  1  origin of the displayed byte: 0 = RX, 1 = TX.
REQ-014 o_Drop  output  1  one-cycle pulse: a TX byte was discarded.

Function
REQ-015 FSM states: BLANK, SHOW, BLINK; all outputs registered.
REQ-016 Capture: i_RX_DV=1 latches i_RX_Byte with o_Source=0; else i_TX_DV=1 latches i_TX_Byte with o_Source=1.
REQ-017 Arbitration: fixed priority, RX over TX; on simultaneous strobes RX is taken, TX is discarded, and o_Drop=1 on the next cycle.
REQ-018 Latency: nibbles, o_Source, and o_Blank=0 appear on the cycle after the capturing edge.
REQ-019 A capture from any state enters SHOW and reloads the hold counter to HOLD_CYCLES-1.
REQ-020 SHOW: the counter decrements each cycle without a capture; at 0 (HOLD_CYCLES cycles after the last capture) the FSM moves to BLINK (macro defined) or BLANK (macro undefined).
REQ-021 BLINK: o_Blank toggles every BLINK_HALF cycles, starting at 1; after 2*BLINK_COUNT half-periods the FSM moves to BLANK.
REQ-022 BLANK: o_Blank=1; nibbles and o_Source keep their last values.
REQ-023 A capture during BLINK aborts the blink immediately: SHOW, o_Blank=0 next cycle.
REQ-024 A capture on the same edge as hold expiry wins: the FSM stays in SHOW and the counter is reloaded.
REQ-025 o_Drop is set only by REQ-017 and is never high for more than one consecutive cycle per event.
REQ-026 Counter widths are $clog2 of the parameter value plus 1; no wrap-around is permitted; counters saturate at 0.

Reset
REQ-027 i_Rst=1 forces state BLANK, o_Blank=1, nibbles 4'h0, o_Source=0, o_Drop=0, and all counters 0, without waiting for a clock edge.
REQ-028 Reset asserted mid-SHOW or mid-BLINK discards the held byte; after release the block waits in BLANK for a strobe.
REQ-029 Strobes present on the first edge after reset release are captured normally.

Configuration
REQ-030 Macro SEG7_BLINK_EN: when defined, the BLINK state and its counters are compiled in and expiry goes SHOW->BLINK->BLANK.
REQ-031 Without SEG7_BLINK_EN: no BLINK logic; expiry goes SHOW->BLANK directly; BLINK_HALF and BLINK_COUNT are ignored.

Verification (HOLD_CYCLES=10, BLINK_HALF=2, BLINK_COUNT=2)
REQ-032 Reset release, no strobes -> o_Blank=1, nibbles 0, o_Drop=0 indefinitely.
REQ-033 i_RX_DV with 8'hA5 -> next cycle o_Upper_Nibble=A, o_Lower_Nibble=5, o_Source=0, o_Blank=0; o_Blank rises 10 cycles after capture (macro off).
REQ-034 i_RX_DV with 8'h3C and i_TX_DV with 8'hF0 on the same edge -> display 3/C, o_Source=0, o_Drop=1 for exactly one cycle.
REQ-035 Macro on, byte 8'h7E, no further strobes -> after 10 cycles o_Blank pattern 1,1,0,0,1,1,0,0, then 1 steady; nibbles stay 7/E.
REQ-036 i_TX_DV with 8'h42 during BLINK -> next cycle o_Blank=0, o_Source=1, display 4/2, hold restarts at 10.
REQ-037 i_Rst pulsed mid-SHOW asynchronously -> o_Blank=1 and nibbles 0 before the next clock edge.

Source files
------------

// File: rtl/seg7_byte_controller.sv
// ---------------------------------------------------------------------------
// seg7_byte_controller
// Holds the last UART byte (RX or TX) on a two-digit 7-segment display for
// HOLD_CYCLES clocks, then blanks the display. RX strobes beat TX strobes. A
// TX byte that arrives together with an RX byte is discarded and reported on
// o_Drop.
//
// Optional feature (macro SEG7_BLINK_EN): when the hold time expires, the
// display blinks BLINK_COUNT off/on periods of 2*BLINK_HALF cycles each
// before it blanks. Without the macro the display blanks at once, and
// BLINK_HALF and BLINK_COUNT have no effect.
//
// Ports:
//   i_Clk           clock, rising edge
//   i_Rst           asynchronous active-high reset
//   i_RX_DV/i_RX_Byte  receive strobe and byte
//   i_TX_DV/i_TX_Byte  transmit strobe and byte
//   o_Upper_Nibble  bits 7:4 of the displayed byte
//   o_Lower_Nibble  bits 3:0 of the displayed byte
//   o_Blank         1 = both digits off
//   o_Source        0 = byte came from RX, 1 = byte came from TX
//   o_Drop          one-cycle pulse when a TX byte is discarded
// ---------------------------------------------------------------------------
module seg7_byte_controller #(
   parameter int unsigned HOLD_CYCLES = 25000000,
   parameter int unsigned BLINK_HALF  = 6250000,
   parameter int unsigned BLINK_COUNT = 4
) (
   input  logic       i_Clk,
   input  logic       i_Rst,
   input  logic       i_RX_DV,
   input  logic [7:0] i_RX_Byte,
   input  logic       i_TX_DV,
   input  logic [7:0] i_TX_Byte,
   output logic [3:0] o_Upper_Nibble,
   output logic [3:0] o_Lower_Nibble,
   output logic       o_Blank,
   output logic       o_Source,
   output logic       o_Drop
);

   localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES) + 1;

   localparam logic [1:0] ST_BLANK = 2'd0;
   localparam logic [1:0] ST_SHOW  = 2'd1;
`ifdef SEG7_BLINK_EN
   localparam logic [1:0] ST_BLINK = 2'd2;
   localparam int unsigned HALF_W  = $clog2(BLINK_HALF) + 1;
   localparam int unsigned CNT_W   = $clog2(BLINK_COUNT) + 1;
`endif

   logic [1:0]        r_State,  w_State_Nxt;
   logic [HOLD_W-1:0] r_Hold,   w_Hold_Nxt;
   logic [7:0]        r_Byte,   w_Byte_Nxt;
   logic              r_Blank,  w_Blank_Nxt;
   logic              r_Source, w_Source_Nxt;
   logic              r_Drop,   w_Drop_Nxt;
   logic              w_Capture;
`ifdef SEG7_BLINK_EN
   logic [HALF_W-1:0] r_Half,   w_Half_Nxt;   // cycles left in current half-period
   logic [CNT_W-1:0]  r_Phase,  w_Phase_Nxt;  // half-periods already completed
`else
   // The blink parameters stay in the port list so builds with and without
   // the feature share one instantiation; they are deliberately unused here.
   logic              w_unused_cfg;
   assign w_unused_cfg = ^{BLINK_HALF, BLINK_COUNT};
`endif

   assign w_Capture = i_RX_DV | i_TX_DV;

   // State and output registers
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         r_State  <= ST_BLANK;
         r_Hold   <= '0;
         r_Byte   <= '0;
         r_Blank  <= 1'b1;
         r_Source <= 1'b0;
         r_Drop   <= 1'b0;
`ifdef SEG7_BLINK_EN
         r_Half   <= '0;
         r_Phase  <= '0;
`endif
      end else begin
         r_State  <= w_State_Nxt;
         r_Hold   <= w_Hold_Nxt;
         r_Byte   <= w_Byte_Nxt;
         r_Blank  <= w_Blank_Nxt;
         r_Source <= w_Source_Nxt;
         r_Drop   <= w_Drop_Nxt;
`ifdef SEG7_BLINK_EN
         r_Half   <= w_Half_Nxt;
         r_Phase  <= w_Phase_Nxt;
`endif
      end
   end

   // Next-state and next-output logic
   always_comb begin
      w_State_Nxt  = r_State;
      w_Hold_Nxt   = r_Hold;
      w_Byte_Nxt   = r_Byte;
      w_Blank_Nxt  = r_Blank;
      w_Source_Nxt = r_Source;
      w_Drop_Nxt   = i_RX_DV & i_TX_DV;
`ifdef SEG7_BLINK_EN
      w_Half_Nxt   = r_Half;
      w_Phase_Nxt  = r_Phase;
`endif

      if (w_Capture) begin
         // A capture wins over expiry and aborts any blink in progress
         w_State_Nxt  = ST_SHOW;
         w_Hold_Nxt   = HOLD_W'(HOLD_CYCLES - 1);
         w_Byte_Nxt   = i_RX_DV ? i_RX_Byte : i_TX_Byte;
         w_Source_Nxt = ~i_RX_DV;
         w_Blank_Nxt  = 1'b0;
`ifdef SEG7_BLINK_EN
         w_Half_Nxt   = '0;
         w_Phase_Nxt  = '0;
`endif
      end else begin
         case (r_State)
            ST_BLANK: begin
               w_Blank_Nxt = 1'b1;
            end
            ST_SHOW: begin
               if (r_Hold == '0) begin
                  w_Blank_Nxt = 1'b1;
`ifdef SEG7_BLINK_EN
                  w_State_Nxt = ST_BLINK;
                  w_Half_Nxt  = HALF_W'(BLINK_HALF - 1);
                  w_Phase_Nxt = '0;
`else
                  w_State_Nxt = ST_BLANK;
`endif
               end else begin
                  w_Hold_Nxt = r_Hold - HOLD_W'(1);
               end
            end
`ifdef SEG7_BLINK_EN
            ST_BLINK: begin
               if (r_Half != '0) begin
                  w_Half_Nxt = r_Half - HALF_W'(1);
               end else if (r_Phase == CNT_W'(2 * BLINK_COUNT - 1)) begin
                  // Last half-period done: blank steadily
                  w_State_Nxt = ST_BLANK;
                  w_Blank_Nxt = 1'b1;
                  w_Phase_Nxt = '0;
               end else begin
                  w_Blank_Nxt = ~r_Blank;
                  w_Half_Nxt  = HALF_W'(BLINK_HALF - 1);
                  w_Phase_Nxt = r_Phase + CNT_W'(1);
               end
            end
`endif
            default: begin
               w_State_Nxt = ST_BLANK;
               w_Blank_Nxt = 1'b1;
            end
         endcase
      end
   end

   assign o_Upper_Nibble = r_Byte[7:4];
   assign o_Lower_Nibble = r_Byte[3:0];
   assign o_Blank        = r_Blank;
   assign o_Source       = r_Source;
   assign o_Drop         = r_Drop;

endmodule

// File: tb/tb_seg7_byte_controller.sv
// ---------------------------------------------------------------------------
// Testbench for seg7_byte_controller with HOLD_CYCLES=10, BLINK_HALF=2 and
// BLINK_COUNT=2. It uses a table of single-cycle vectors that work with or
// without SEG7_BLINK_EN, then hand-written multi-cycle sequences.
// ---------------------------------------------------------------------------
module tb_seg7_byte_controller;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_dv = 1'b0;
   logic [7:0] rx_byte = 8'h00;
   logic       tx_dv = 1'b0;
   logic [7:0] tx_byte = 8'h00;
   logic [3:0] up, lo;
   logic       blank, src, drop;

   int checks = 0;
   int failures = 0;

`ifdef SEG7_BLINK_EN
   localparam bit BLINK_ON = 1'b1;
`else
   localparam bit BLINK_ON = 1'b0;
`endif

   seg7_byte_controller #(
      .HOLD_CYCLES(10),
      .BLINK_HALF (2),
      .BLINK_COUNT(2)
   ) dut (
      .i_Clk         (clk),
      .i_Rst         (rst),
      .i_RX_DV       (rx_dv),
      .i_RX_Byte     (rx_byte),
      .i_TX_DV       (tx_dv),
      .i_TX_Byte     (tx_byte),
      .o_Upper_Nibble(up),
      .o_Lower_Nibble(lo),
      .o_Blank       (blank),
      .o_Source      (src),
      .o_Drop        (drop)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       rx_dv;
      logic [7:0] rx_b;
      logic       tx_dv;
      logic [7:0] tx_b;
      logic [3:0] up;
      logic [3:0] lo;
      logic       bl;
      logic       src;
      logic       drp;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic r, logic rd, logic [7:0] rb, logic td, logic [7:0] tb,
                               logic [3:0] eu, logic [3:0] el, logic eb, logic es, logic ed);
      vec_t v;
      v.rst = r; v.rx_dv = rd; v.rx_b = rb; v.tx_dv = td; v.tx_b = tb;
      v.up = eu; v.lo = el; v.bl = eb; v.src = es; v.drp = ed;
      return v;
   endfunction

   task automatic check(string name, logic [3:0] eu, logic [3:0] el, logic eb, logic es, logic ed);
      checks++;
      if (up !== eu || lo !== el || blank !== eb || src !== es || drop !== ed) begin
         failures++;
         $display("FAIL %s: got up=%h lo=%h blank=%b src=%b drop=%b, want up=%h lo=%h blank=%b src=%b drop=%b",
                  name, up, lo, blank, src, drop, eu, el, eb, es, ed);
      end
   endtask

   // Present strobes for one clock edge, then sample 1 time unit after it
   task automatic apply(logic rd, logic [7:0] rb, logic td, logic [7:0] tb);
      rx_dv = rd; rx_byte = rb; tx_dv = td; tx_byte = tb;
      @(posedge clk);
      #1;
      rx_dv = 1'b0; tx_dv = 1'b0;
   endtask

   task automatic idle();
      apply(1'b0, 8'h00, 1'b0, 8'h00);
   endtask

   initial begin
      // --- table of single-edge vectors (identical results in both builds) ---
      vecs.push_back(mk(1, 0, 8'h00, 0, 8'h00, 4'h0, 4'h0, 1, 0, 0)); // reset
      vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 4'h0, 4'h0, 1, 0, 0)); // idle after release
      vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 4'h0, 4'h0, 1, 0, 0));
      vecs.push_back(mk(0, 1, 8'hA5, 0, 8'h00, 4'hA, 4'h5, 0, 0, 0)); // RX capture
      for (int i = 0; i < 9; i++)
         vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 4'hA, 4'h5, 0, 0, 0));
      vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 4'hA, 4'h5, 1, 0, 0)); // expiry, 10 after capture
      vecs.push_back(mk(0, 1, 8'h3C, 1, 8'hF0, 4'h3, 4'hC, 0, 0, 1)); // collision, RX wins
      vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 4'h3, 4'hC, 0, 0, 0)); // drop lasts one cycle
      vecs.push_back(mk(0, 0, 8'h00, 1, 8'h42, 4'h4, 4'h2, 0, 1, 0)); // TX capture
      vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 4'h4, 4'h2, 0, 1, 0));
      vecs.push_back(mk(1, 0, 8'h00, 0, 8'h00, 4'h0, 4'h0, 1, 0, 0)); // reset mid-SHOW
      vecs.push_back(mk(0, 1, 8'h81, 0, 8'h00, 4'h8, 4'h1, 0, 0, 0)); // strobe on first edge
      vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 4'h8, 4'h1, 0, 0, 0));

      foreach (vecs[i]) begin
         rst = vecs[i].rst;
         apply(vecs[i].rx_dv, vecs[i].rx_b, vecs[i].tx_dv, vecs[i].tx_b);
         check($sformatf("vec%0d", i), vecs[i].up, vecs[i].lo, vecs[i].bl, vecs[i].src, vecs[i].drp);
      end

      // --- capture on the same edge as hold expiry reloads the hold ---
      apply(1'b1, 8'h5A, 1'b0, 8'h00);
      check("exp_cap", 4'h5, 4'hA, 0, 0, 0);
      for (int k = 1; k <= 9; k++) idle();
      check("exp_pre", 4'h5, 4'hA, 0, 0, 0);
      apply(1'b0, 8'h00, 1'b1, 8'h99);
      check("exp_recap", 4'h9, 4'h9, 0, 1, 0);
      for (int k = 1; k <= 9; k++) idle();
      check("exp_hold9", 4'h9, 4'h9, 0, 1, 0);
      idle();
      check("exp_hold10", 4'h9, 4'h9, 1, 1, 0);

      // --- asynchronous reset in the middle of SHOW ---
      apply(1'b1, 8'h12, 1'b0, 8'h00);
      check("ar_cap", 4'h1, 4'h2, 0, 0, 0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("ar_async", 4'h0, 4'h0, 1, 0, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle();
      check("ar_wait", 4'h0, 4'h0, 1, 0, 0);

      // --- blink abort by a TX capture ---
      apply(1'b1, 8'h7E, 1'b0, 8'h00);
      check("ab_cap", 4'h7, 4'hE, 0, 0, 0);
      for (int k = 1; k <= 12; k++) idle();
      check("ab_e12", 4'h7, 4'hE, BLINK_ON ? 1'b0 : 1'b1, 0, 0);
      apply(1'b0, 8'h00, 1'b1, 8'h42);
      check("ab_tx", 4'h4, 4'h2, 0, 1, 0);
      for (int k = 1; k <= 9; k++) idle();
      check("ab_hold9", 4'h4, 4'h2, 0, 1, 0);
      idle();
      check("ab_hold10", 4'h4, 4'h2, 1, 1, 0);

      // --- full expiry pattern with no further strobes ---
      apply(1'b1, 8'h7E, 1'b0, 8'h00);
      check("bl_cap", 4'h7, 4'hE, 0, 0, 0);
      for (int k = 1; k <= 21; k++) begin
         logic exp_bl;
         if (k <= 9)
            exp_bl = 1'b0;
         else if (BLINK_ON && k <= 17)
            exp_bl = (((k - 10) / 2) % 2 == 0) ? 1'b1 : 1'b0;
         else
            exp_bl = 1'b1;
         idle();
         check($sformatf("bl_k%0d", k), 4'h7, 4'hE, exp_bl, 0, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
